// File: rtl/aes_sched_pkg.sv
// Shared definitions for the AES request scheduler: FSM state encoding,
// block width, default core timeout and the round-robin pointer helper.
package aes_sched_pkg;

  localparam int AES_BLK_W          = 128;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    BUSY = 2'd2,
    RESP = 2'd3
  } sched_state_t;

  // Pointer value that follows a grant, wrapping back to requester 0.
  function automatic int rr_next(input int grant, input int n_req);
    int nxt;
    if (grant + 1 >= n_req) begin
      nxt = 0;
    end else begin
      nxt = grant + 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first pending request at or
// after the pointer, wrapping modulo N_REQ. Returns one-hot and encoded grant.
module aes_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_any
);

  logic [ID_W-1:0] w_idx;
  logic            w_found;
  int              w_pos;
  logic            w_hit;

  // Scan requesters starting at the pointer; the first set bit wins.
  always_comb begin
    w_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    w_hit   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      w_pos   = int'(i_ptr) + i;
      w_pos   = (w_pos >= N_REQ) ? (w_pos - N_REQ) : w_pos;
      w_hit   = i_req[w_pos] & ~w_found;
      w_idx   = w_hit ? ID_W'(w_pos) : w_idx;
      w_found = w_found | w_hit;
    end
  end

  assign o_idx   = w_idx;
  assign o_any   = w_found;
  assign o_grant = w_found ? (N_REQ'(1'b1) << w_idx) : '0;

endmodule

// File: rtl/aes_req_scheduler.sv
// Shares one aes_cipher_top core between N_REQ requesters. Pending requests
// are granted round-robin, operands are held in registers while the core
// runs, and the ciphertext is returned tagged with the requester id.
// Optional macro AES_SCHED_TIMEOUT_EN adds a core timeout and the resp_err
// port; without it the block waits for core_done indefinitely.
module aes_req_scheduler
  import aes_sched_pkg::*;
#(
  parameter int N_REQ = 4,
`ifdef AES_SCHED_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
`endif
  parameter int ID_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*AES_BLK_W-1:0] req_key,
  input  logic [N_REQ*AES_BLK_W-1:0] req_text,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic [AES_BLK_W-1:0]       resp_data,
`ifdef AES_SCHED_TIMEOUT_EN
  output logic                       resp_err,
`endif
  output logic                       core_ld,
  output logic [AES_BLK_W-1:0]       core_key,
  output logic [AES_BLK_W-1:0]       core_text,
  input  logic                       core_done,
  input  logic [AES_BLK_W-1:0]       core_text_out
);

  sched_state_t         r_state;
  logic [ID_W-1:0]      r_rr_ptr;
  logic [ID_W-1:0]      r_grant;
  logic                 r_core_ld;
  logic [AES_BLK_W-1:0] r_core_key;
  logic [AES_BLK_W-1:0] r_core_text;
  logic                 r_resp_valid;
  logic [ID_W-1:0]      r_resp_id;
  logic [AES_BLK_W-1:0] r_resp_data;

`ifdef AES_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic             r_resp_err;
  logic [CNT_W-1:0] r_tmo_cnt;
`endif

  logic [N_REQ-1:0]     w_grant_oh;
  logic [ID_W-1:0]      w_grant_idx;
  logic                 w_any;
  logic [AES_BLK_W-1:0] w_sel_key;
  logic [AES_BLK_W-1:0] w_sel_text;

  aes_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant_oh),
    .o_idx   (w_grant_idx),
    .o_any   (w_any)
  );

  assign w_sel_key  = req_key[w_grant_idx*AES_BLK_W +: AES_BLK_W];
  assign w_sel_text = req_text[w_grant_idx*AES_BLK_W +: AES_BLK_W];

  // The accept strobe is only offered while idle; it is zero when nothing is pending.
  assign req_ready = (r_state == IDLE) ? w_grant_oh : '0;

  // Scheduler FSM: accept, pulse ld, wait for done (or timeout), hold response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_core_ld    <= 1'b0;
      r_core_key   <= '0;
      r_core_text  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
`ifdef AES_SCHED_TIMEOUT_EN
      r_resp_err   <= 1'b0;
      r_tmo_cnt    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_core_key  <= w_sel_key;
            r_core_text <= w_sel_text;
            r_grant     <= w_grant_idx;
            r_core_ld   <= 1'b1;
            r_state     <= LOAD;
          end else begin
            r_core_ld   <= 1'b0;
            r_state     <= IDLE;
          end
        end
        LOAD: begin
          // A done seen here (coinciding with ld) is deliberately ignored.
          r_core_ld <= 1'b0;
          r_state   <= BUSY;
`ifdef AES_SCHED_TIMEOUT_EN
          r_tmo_cnt <= '0;
`endif
        end
        BUSY: begin
          if (core_done) begin
            r_resp_data  <= core_text_out;
            r_resp_id    <= r_grant;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
`ifdef AES_SCHED_TIMEOUT_EN
            r_resp_err   <= 1'b0;
          end else if (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_resp_data  <= '0;
            r_resp_id    <= r_grant;
            r_resp_err   <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_tmo_cnt    <= r_tmo_cnt + CNT_W'(1);
            r_state      <= BUSY;
          end
`else
          end else begin
            r_state      <= BUSY;
          end
`endif
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_rr_ptr     <= ID_W'(rr_next(int'(r_grant), N_REQ));
            r_state      <= IDLE;
`ifdef AES_SCHED_TIMEOUT_EN
            r_resp_err   <= 1'b0;
`endif
          end else begin
            r_state      <= RESP;
          end
        end
        default: begin
          r_core_ld <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign core_ld    = r_core_ld;
  assign core_key   = r_core_key;
  assign core_text  = r_core_text;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
`ifdef AES_SCHED_TIMEOUT_EN
  assign resp_err   = r_resp_err;
`endif

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Directed bench for aes_req_scheduler. The bench plays the AES core itself,
// returning known FIPS-197 ciphertexts for the operands it expects.
module tb_aes_req_scheduler;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [511:0] req_key;
  logic [511:0] req_text;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic [127:0] resp_data;
`ifdef AES_SCHED_TIMEOUT_EN
  logic         resp_err;
`endif
  logic         core_ld;
  logic [127:0] core_key;
  logic [127:0] core_text;
  logic         core_done;
  logic [127:0] core_text_out;

  int total = 0;
  int bad   = 0;

  aes_req_scheduler #(.N_REQ(4), .ID_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_key       (req_key),
    .req_text      (req_text),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_data     (resp_data),
`ifdef AES_SCHED_TIMEOUT_EN
    .resp_err      (resp_err),
`endif
    .core_ld       (core_ld),
    .core_key      (core_key),
    .core_text     (core_text),
    .core_done     (core_done),
    .core_text_out (core_text_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [127:0] k, input logic [127:0] t);
    req_key[i*128 +: 128]  = k;
    req_text[i*128 +: 128] = t;
  endtask

  // One full transaction starting in IDLE at a falling edge with requests set.
  task automatic do_txn(input int id, input logic [127:0] k, input logic [127:0] p,
                        input logic [127:0] c, input int lat, input bit drop);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    #1;
    chk("accept_ready", 128'(req_ready), 128'(oh));
    @(negedge clk);
    if (drop) req_valid = 4'b0000;
    #1;
    chk("ld_pulse", 128'(core_ld), 128'(1'b1));
    chk("core_key", core_key, k);
    chk("core_text", core_text, p);
    chk("ready_in_load", 128'(req_ready), 128'(4'b0000));
    @(negedge clk);
    chk("ld_one_cycle", 128'(core_ld), 128'(1'b0));
    for (int j = 1; j < lat; j++) @(negedge clk);
    chk("no_early_resp", 128'(resp_valid), 128'(1'b0));
    core_done     = 1'b1;
    core_text_out = c;
    @(negedge clk);
    core_done     = 1'b0;
    core_text_out = '0;
    chk("resp_valid", 128'(resp_valid), 128'(1'b1));
    chk("resp_id", 128'(resp_id), 128'(id));
    chk("resp_data", resp_data, c);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_drop", 128'(resp_valid), 128'(1'b0));
  endtask

  initial begin
    rst = 1'b0; req_valid = 4'b0000; req_key = '0; req_text = '0;
    resp_ready = 1'b0; core_done = 1'b0; core_text_out = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_req_ready", 128'(req_ready), 128'(4'b0000));
    chk("rst_core_ld", 128'(core_ld), 128'(1'b0));
    chk("rst_core_key", core_key, 128'h0);
    chk("rst_core_text", core_text, 128'h0);
    chk("rst_resp_valid", 128'(resp_valid), 128'(1'b0));
    chk("rst_resp_id", 128'(resp_id), 128'(2'd0));
    chk("rst_resp_data", resp_data, 128'h0);
`ifdef AES_SCHED_TIMEOUT_EN
    chk("rst_resp_err", 128'(resp_err), 128'(1'b0));
`endif
    rst = 1'b1;
    @(negedge clk);

    // Fairness: all four requesting continuously -> 0,1,2,3,0
    for (int i = 0; i < 4; i++) set_slot(i, K2, P2);
    req_valid = 4'b1111;
    do_txn(0, K2, P2, C2, 2, 1'b0);
    do_txn(1, K2, P2, C2, 1, 1'b0);
    do_txn(2, K2, P2, C2, 3, 1'b0);
    do_txn(3, K2, P2, C2, 1, 1'b0);
    do_txn(0, K2, P2, C2, 2, 1'b1);

    // Single request from requester 1 (pointer now 1)
    set_slot(1, K1, P1);
    req_valid = 4'b0010;
    do_txn(1, K1, P1, C1, 1, 1'b1);

    // Backpressure on requester 3's response while requester 0 waits
    req_valid = 4'b1000;
    #1;
    chk("bp_accept", 128'(req_ready), 128'(4'b1000));
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    core_done = 1'b1; core_text_out = C2;
    @(negedge clk);
    core_done = 1'b0; core_text_out = '0;
    req_valid = 4'b0001;
    for (int n = 0; n < 20; n++) begin
      #1;
      chk("bp_valid", 128'(resp_valid), 128'(1'b1));
      chk("bp_data", resp_data, C2);
      chk("bp_id", 128'(resp_id), 128'(2'd3));
      chk("bp_no_ready", 128'(req_ready), 128'(4'b0000));
      chk("bp_no_ld", 128'(core_ld), 128'(1'b0));
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("bp_released", 128'(resp_valid), 128'(1'b0));
    // Grant 3 wrapped the pointer to 0, so requester 0 is next
    do_txn(0, K2, P2, C2, 1, 1'b1);

    // A request withdrawn before any clock edge is never granted
    req_valid = 4'b0001;
    #2;
    req_valid = 4'b0000;
    @(negedge clk);
    chk("withdrawn_no_ld", 128'(core_ld), 128'(1'b0));

    // Spurious done in IDLE
    core_done = 1'b1; core_text_out = 128'hdeadbeef;
    @(negedge clk);
    core_done = 1'b0; core_text_out = '0;
    chk("idle_done_no_resp", 128'(resp_valid), 128'(1'b0));
    chk("idle_done_no_ld", 128'(core_ld), 128'(1'b0));

    // Spurious done coinciding with ld, then the genuine done
    set_slot(2, K1, P1);
    req_valid = 4'b0100;
    #1;
    chk("sp_accept", 128'(req_ready), 128'(4'b0100));
    @(negedge clk);
    req_valid = 4'b0000;
    core_done = 1'b1; core_text_out = 128'hbad0;
    #1;
    chk("sp_ld", 128'(core_ld), 128'(1'b1));
    @(negedge clk);
    core_done = 1'b0; core_text_out = '0;
    chk("sp_load_done_ignored", 128'(resp_valid), 128'(1'b0));
    @(negedge clk);
    chk("sp_still_busy", 128'(resp_valid), 128'(1'b0));
    core_done = 1'b1; core_text_out = C1;
    @(negedge clk);
    core_done = 1'b0; core_text_out = '0;
    chk("sp_resp_valid", 128'(resp_valid), 128'(1'b1));
    chk("sp_resp_id", 128'(resp_id), 128'(2'd2));
    chk("sp_resp_data", resp_data, C1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;

    // Reset during BUSY drops the request and clears the pointer
    req_valid = 4'b0010;
    #1;
    chk("rb_accept", 128'(req_ready), 128'(4'b0010));
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rb_core_ld", 128'(core_ld), 128'(1'b0));
    chk("rb_core_key", core_key, 128'h0);
    chk("rb_core_text", core_text, 128'h0);
    chk("rb_resp_valid", 128'(resp_valid), 128'(1'b0));
    chk("rb_resp_data", resp_data, 128'h0);
    chk("rb_req_ready", 128'(req_ready), 128'(4'b0000));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rb_no_resp", 128'(resp_valid), 128'(1'b0));
    set_slot(3, K1, P1);
    req_valid = 4'b1100;
    do_txn(2, K1, P1, C1, 2, 1'b1);
    req_valid = 4'b1000;
    do_txn(3, K1, P1, C1, 1, 1'b1);

`ifdef AES_SCHED_TIMEOUT_EN
    // Core never answers: error response 65 cycles after ld
    begin
      int n;
      req_valid = 4'b0001;
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      chk("to_ld", 128'(core_ld), 128'(1'b1));
      n = 0;
      while (n < 200 && resp_valid !== 1'b1) begin
        @(negedge clk);
        n++;
      end
      chk("to_latency", 128'(n), 128'(65));
      chk("to_err", 128'(resp_err), 128'(1'b1));
      chk("to_data", resp_data, 128'h0);
      chk("to_id", 128'(resp_id), 128'(2'd0));
      core_done = 1'b1; core_text_out = C2;
      @(negedge clk);
      core_done = 1'b0; core_text_out = '0;
      chk("to_late_done", resp_data, 128'h0);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk("to_err_clear", 128'(resp_err), 128'(1'b0));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
